// File: rtl/prog_timer.sv
// prog_timer: programmable down-counting timer with prescaler.
// Load a start value with preset. It then counts down once every prescale+1
// clocks and raises a one-cycle time_out pulse when it expires. In one-shot
// mode it returns to IDLE after expiry. In periodic mode it reloads and keeps
// running. It also supports pause, abort (stop), a live count readout and a
// sticky expired flag.

module prog_timer #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             preset,
    input  logic [WIDTH-1:0] preset_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic             mode,
    input  logic             pause,
    input  logic             stop,
    input  logic             clr,
    output logic             time_out,
    output logic             expired,
    output logic             running,
    output logic [WIDTH-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count_r, count_next;
    logic [WIDTH-1:0] reload_r, reload_next;
    logic [PS_W-1:0]  ps_cnt, ps_cnt_next;
    logic [PS_W-1:0]  ps_r, ps_r_next;
    logic             mode_r, mode_next;
    logic             time_out_r, time_out_next;
    logic             expired_r, expired_next;
    logic             tick;
    logic             expire;

    // Register the state, the datapath and the registered outputs.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the values from before the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count_r    <= '0;
            reload_r   <= '0;
            ps_cnt     <= '0;
            ps_r       <= '0;
            mode_r     <= 1'b0;
            time_out_r <= 1'b0;
            expired_r  <= 1'b0;
        end else begin
            state      <= state_next;
            count_r    <= count_next;
            reload_r   <= reload_next;
            ps_cnt     <= ps_cnt_next;
            ps_r       <= ps_r_next;
            mode_r     <= mode_next;
            time_out_r <= time_out_next;
            expired_r  <= expired_next;
        end
    end

    // A tick is one prescaled time step. The counter is live only in RUN
    // while not paused.
    assign tick   = (state == RUN) && !pause && (ps_cnt == ps_r);
    // Expiry is a tick at zero that neither preset nor stop overrides.
    assign expire = !preset && !stop && tick && (count_r == '0);

    // Next-state and datapath update. Priority is preset, then stop, then tick.
    always_comb begin
        // NOTE: every signal gets a hold/default value first, so no path can
        // leave one unassigned and infer a latch.
        state_next    = state;
        count_next    = count_r;
        reload_next   = reload_r;
        ps_cnt_next   = ps_cnt;
        ps_r_next     = ps_r;
        mode_next     = mode_r;
        time_out_next = 1'b0;

        if (preset) begin
            count_next  = preset_val;
            reload_next = preset_val;
            ps_r_next   = prescale;
            mode_next   = mode;
            ps_cnt_next = '0;
            state_next  = RUN;
        end else if (stop) begin
            state_next  = IDLE;
            count_next  = '0;
            ps_cnt_next = '0;
        end else if (state == RUN && !pause) begin
            if (ps_cnt != ps_r) begin
                ps_cnt_next = ps_cnt + 1'b1;
            end else begin
                ps_cnt_next = '0;
                if (count_r != '0) begin
                    count_next = count_r - 1'b1;
                end else begin
                    time_out_next = 1'b1;
                    if (mode_r) begin
                        count_next = reload_r;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        end
    end

    // Sticky flag: preset clears it, and expiry wins over clr at the same edge.
    always_comb begin
        expired_next = expired_r;
        if (preset) begin
            expired_next = 1'b0;
        end else if (expire) begin
            expired_next = 1'b1;
        end else if (clr) begin
            expired_next = 1'b0;
        end
    end

    // Output decode from registered state.
    always_comb begin
        running  = (state == RUN);
        count    = count_r;
        time_out = time_out_r;
        expired  = expired_r;
    end

endmodule
